// File: rtl/test_7seg_frame_capture_if.sv
// test_7seg_frame_capture_if
//   Groups the display-bus, handshake and flag signals of the 7-segment
//   frame capture monitor.
//   master : testbench side (drives i_*, observes o_*)
//   slave  : monitor side (observes i_*, drives o_*)
//   i_en, i_led[6:0], i_digit_sel[NUM_DIGITS-1:0], i_frame_ready, i_clear_flags
//   o_bcd[4*NUM_DIGITS-1:0], o_seg_err[NUM_DIGITS-1:0], o_frame_valid,
//   o_overrun, o_sel_err
interface test_7seg_frame_capture_if #(
  parameter int NUM_DIGITS = 6
);
  logic                    i_en;
  logic [6:0]              i_led;
  logic [NUM_DIGITS-1:0]   i_digit_sel;
  logic                    i_frame_ready;
  logic                    i_clear_flags;
  logic [4*NUM_DIGITS-1:0] o_bcd;
  logic [NUM_DIGITS-1:0]   o_seg_err;
  logic                    o_frame_valid;
  logic                    o_overrun;
  logic                    o_sel_err;

  modport master (
    output i_en, i_led, i_digit_sel, i_frame_ready, i_clear_flags,
    input  o_bcd, o_seg_err, o_frame_valid, o_overrun, o_sel_err
  );

  modport slave (
    input  i_en, i_led, i_digit_sel, i_frame_ready, i_clear_flags,
    output o_bcd, o_seg_err, o_frame_valid, o_overrun, o_sel_err
  );
endinterface

// File: rtl/test_7seg_frame_capture.sv
// test_7seg_frame_capture
//   Samples a multiplexed 7-segment bus, waits for each digit to be stable
//   for SETTLE_CYCLES cycles, decodes it to BCD and assembles a full frame
//   that is presented over a valid/ready handshake. Flags undecodable
//   segment patterns, multi-hot selects (sticky) and dropped frames (sticky).
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high reset
//   bus     : test_7seg_frame_capture_if.slave (inputs i_*, outputs o_*)
module test_7seg_frame_capture #(
  parameter int NUM_DIGITS     = 6,
  parameter int SETTLE_CYCLES  = 2,
  parameter int SEL_ACTIVE_LOW = 0,
  parameter int ONLY_ON_CHANGE = 0
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  test_7seg_frame_capture_if.slave   bus
);
  localparam int              ND      = NUM_DIGITS;
  localparam logic [7:0]      SETTLE  = 8'(SETTLE_CYCLES);
  localparam logic [ND-1:0]   SEL_ONE = ND'(1);

  typedef enum logic [1:0] {IDLE, COLLECT, COMPLETE} state_t;

  state_t          state_reg;
  logic [ND-1:0]   prev_sel_reg;
  logic [6:0]      prev_led_reg;
  logic [7:0]      settle_cnt_reg;
  logic [7:0]      settle_cnt_next;
  logic [ND-1:0]   collect_mask_reg;
  logic [ND-1:0]   collect_mask_next;

  logic [3:0]      frame_digit_reg [ND];
  logic            frame_err_reg   [ND];
  logic [4*ND-1:0] frame_bcd;
  logic [ND-1:0]   frame_err;

  logic [4*ND-1:0] bcd_reg;
  logic [ND-1:0]   seg_err_reg;
  logic            frame_valid_reg;
  logic            overrun_reg;
  logic            sel_err_reg;

  logic [ND-1:0]   sel;
  logic            sel_onehot;
  logic            sel_multi;
  logic            stable;
  logic            latch;
  logic            latch_en;
  logic [3:0]      dec_digit;
  logic            dec_err;
  logic            in_complete;
  logic            suppress;
  logic            load_frame;
  logic            drop_frame;
  logic            accept;

  // Select normalisation and classification
  always_comb begin
    sel        = (SEL_ACTIVE_LOW != 0) ? ~bus.i_digit_sel : bus.i_digit_sel;
    sel_onehot = (sel != '0) && ((sel & (sel - SEL_ONE)) == '0);
    sel_multi  = (sel != '0) && !sel_onehot;
  end

  // Settle counter and latch strobe. A held, already-saturated dwell does
  // not re-latch; any restarted dwell may latch again.
  always_comb begin
    stable = sel_onehot && (sel == prev_sel_reg) && (bus.i_led == prev_led_reg);
    if (stable)
      settle_cnt_next = (settle_cnt_reg >= SETTLE) ? SETTLE : settle_cnt_reg + 8'd1;
    else if (sel_onehot)
      settle_cnt_next = 8'd1;
    else
      settle_cnt_next = 8'd0;
    latch = (settle_cnt_next == SETTLE) && !(stable && (settle_cnt_reg == SETTLE));
  end

  // Segment decoder {a,b,c,d,e,f,g}
  always_comb begin
    dec_err = 1'b0;
    case (bus.i_led)
      7'b1111110: dec_digit = 4'd0;
      7'b0110000: dec_digit = 4'd1;
      7'b1101101: dec_digit = 4'd2;
      7'b1111001: dec_digit = 4'd3;
      7'b0110011: dec_digit = 4'd4;
      7'b1011011: dec_digit = 4'd5;
      7'b1011111: dec_digit = 4'd6;
      7'b1110000: dec_digit = 4'd7;
      7'b1111111: dec_digit = 4'd8;
      7'b1111011: dec_digit = 4'd9;
      default: begin
        dec_digit = 4'hF;
        dec_err   = 1'b1;
      end
    endcase
  end

  // The COMPLETE cycle hands the assembled frame off; latches in that
  // cycle are ignored so the frame being handed off is never disturbed.
  always_comb begin
    in_complete       = bus.i_en && (state_reg == COMPLETE);
    latch_en          = bus.i_en && (state_reg != COMPLETE) && latch;
    collect_mask_next = collect_mask_reg | (latch_en ? sel : '0);
    suppress          = (ONLY_ON_CHANGE != 0) && (frame_bcd == bcd_reg);
    accept            = frame_valid_reg && bus.i_frame_ready;
    load_frame        = in_complete && !suppress && (!frame_valid_reg || bus.i_frame_ready);
    drop_frame        = in_complete && !suppress && frame_valid_reg && !bus.i_frame_ready;
  end

  // Per-digit frame buffer
  for (genvar gi = 0; gi < ND; gi++) begin : g_digit
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        frame_digit_reg[gi] <= 4'd0;
        frame_err_reg[gi]   <= 1'b0;
      end else if (latch_en && sel[gi]) begin
        frame_digit_reg[gi] <= dec_digit;
        frame_err_reg[gi]   <= dec_err;
      end
    end
    assign frame_bcd[4*gi +: 4] = frame_digit_reg[gi];
    assign frame_err[gi]        = frame_err_reg[gi];
  end

  // Control FSM, handshake and sticky flags
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg        <= IDLE;
      prev_sel_reg     <= '0;
      prev_led_reg     <= '0;
      settle_cnt_reg   <= '0;
      collect_mask_reg <= '0;
      bcd_reg          <= '1;
      seg_err_reg      <= '0;
      frame_valid_reg  <= 1'b0;
      overrun_reg      <= 1'b0;
      sel_err_reg      <= 1'b0;
    end else begin
      if (!bus.i_en) begin
        state_reg        <= IDLE;
        prev_sel_reg     <= '0;
        prev_led_reg     <= '0;
        settle_cnt_reg   <= '0;
        collect_mask_reg <= '0;
      end else begin
        prev_sel_reg   <= sel;
        prev_led_reg   <= bus.i_led;
        settle_cnt_reg <= settle_cnt_next;
        if (state_reg == COMPLETE) begin
          collect_mask_reg <= '0;
          state_reg        <= COLLECT;
        end else begin
          collect_mask_reg <= collect_mask_next;
          state_reg        <= (&collect_mask_next) ? COMPLETE : COLLECT;
        end
      end

      if (load_frame) begin
        bcd_reg         <= frame_bcd;
        seg_err_reg     <= frame_err;
        frame_valid_reg <= 1'b1;
      end else if (accept) begin
        frame_valid_reg <= 1'b0;
      end

      // Set beats clear when both happen in the same cycle
      if (drop_frame)
        overrun_reg <= 1'b1;
      else if (bus.i_clear_flags)
        overrun_reg <= 1'b0;

      if (bus.i_en && sel_multi)
        sel_err_reg <= 1'b1;
      else if (bus.i_clear_flags)
        sel_err_reg <= 1'b0;
    end
  end

  assign bus.o_bcd         = bcd_reg;
  assign bus.o_seg_err     = seg_err_reg;
  assign bus.o_frame_valid = frame_valid_reg;
  assign bus.o_overrun     = overrun_reg;
  assign bus.o_sel_err     = sel_err_reg;
endmodule
